// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryption core: runs the forward key schedule to the last
// round key, then unwinds one round per clock while undoing the cipher rounds.
module present80_dec #(
    parameter int NUM_ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ciphertext,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plaintext
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid, once raised, holds with stable data until that edge.

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} fsm_t;

    localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

    fsm_t        fsm_q, fsm_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [63:0] pt_q, pt_d;

    logic [79:0] key_fwd;
    logic [79:0] key_inv;
    logic [63:0] state_dec;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5; 4'h1: y = 4'hE; 4'h2: y = 4'hF; 4'h3: y = 4'h8;
            4'h4: y = 4'hC; 4'h5: y = 4'h1; 4'h6: y = 4'h2; 4'h7: y = 4'hD;
            4'h8: y = 4'hB; 4'h9: y = 4'h4; 4'hA: y = 4'h6; 4'hB: y = 4'h3;
            4'hC: y = 4'h0; 4'hD: y = 4'h7; 4'hE: y = 4'h9; default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sinv_layer(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[4*i +: 4] = sbox_inv(x[4*i +: 4]);
        end
        return o;
    endfunction

    // Bit i of the result is the bit that the forward permutation moved to position P(i).
    function automatic logic [63:0] pinv(input logic [63:0] x);
        logic [63:0] o;
        int          j;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            j = (16 * i) % 63;
            o[i[5:0]] = x[j[5:0]];
        end
        o[63] = x[63];
        return o;
    endfunction

    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ c;
        return r;
    endfunction

    // Exact inverse of fwd_update for the same counter value.
    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r = k;
        r[19:15] = r[19:15] ^ c;
        r[79:76] = sbox_inv(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    assign key_fwd   = fwd_update(key_q, cnt_q);
    assign key_inv   = inv_update(key_q, cnt_q);
    assign state_dec = sinv_layer(pinv(state_q)) ^ key_inv[79:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            key_q   <= '0;
            pt_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        key_d   = key_q;
        pt_d    = pt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ciphertext;
                    key_d   = key;
                    cnt_d   = 5'd1;
                    fsm_d   = KEYEXP;
                end
            end
            KEYEXP: begin
                key_d = key_fwd;
                if (cnt_q == LAST) begin
                    // Final whitening with the last round key; the counter stays put
                    // so the first decryption round unwinds this same update.
                    state_d = state_q ^ key_fwd[79:16];
                    fsm_d   = DEC;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DEC: begin
                key_d   = key_inv;
                state_d = state_dec;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    pt_d  = state_dec;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign plaintext = pt_q;

endmodule

// File: tb/tb_present80_dec.sv
// Directed bench for present80_dec: known-answer vectors, exact latency,
// key-register restoration, reset abort, output stall and back-to-back blocks.
module tb_present80_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;

    typedef struct {
        logic [63:0] ct;
        logic [79:0] key;
        logic [63:0] pt;
    } vec_t;

    vec_t vecs[4];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   lat;

    always #5 clk = ~clk;

    present80_dec #(.NUM_ROUNDS(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Offers v in IDLE; returns at the negedge after the accepting edge with inputs scrambled.
    task automatic start(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 80'(in_ready), 80'(1));
        in_valid   = 1'b1;
        ciphertext = v.ct;
        key        = v.key;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        ciphertext = {$urandom, $urandom};
        key        = {16'($urandom), $urandom, $urandom};
        check("busy_in_ready", 80'(in_ready), 80'(0));
    endtask

    // Counts edges after the accepting edge until out_valid is seen at a negedge.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", 80'(edges), 80'(62));
    endtask

    task automatic handshake(input logic [63:0] exp_pt);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_out_valid", 80'(out_valid), 80'(0));
        check("hs_in_ready", 80'(in_ready), 80'(1));
        check("hs_pt_hold", 80'(plaintext), 80'(exp_pt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h5579C1387B228445, 80'h0,                    64'h0000000000000000};
        vecs[1] = '{64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h0000000000000000};
        vecs[2] = '{64'hA112FFC72F68417B, 80'h0,                    64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{64'h3333DCD3213210D2, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        key        = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 80'(in_ready), 80'(1));
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_plaintext", 80'(plaintext), 80'(0));
        check("rst_key_reg", dut.key_q, 80'(0));
        rst = 1'b0;

        // Known-answer vectors
        for (int i = 0; i < 4; i++) begin
            start(vecs[i]);
            wait_done(lat);
            check($sformatf("vec%0d_pt", i), 80'(plaintext), 80'(vecs[i].pt));
            check($sformatf("vec%0d_key_reg", i), dut.key_q, vecs[i].key);
            handshake(vecs[i].pt);
        end

        // Reset 40 edges into an operation (inside the decryption rounds)
        start(vecs[0]);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 80'(in_ready), 80'(1));
        check("midrst_out_valid", 80'(out_valid), 80'(0));
        check("midrst_plaintext", 80'(plaintext), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        start(vecs[1]);
        wait_done(lat);
        check("after_rst_pt", 80'(plaintext), 80'(vecs[1].pt));
        handshake(vecs[1].pt);

        // Output stall with in_valid pulsed while busy
        start(vecs[2]);
        wait_done(lat);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_valid   = 1'b1;
                ciphertext = vecs[3].ct;
                key        = vecs[3].key;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("stall%0d_valid", c), 80'(out_valid), 80'(1));
            check($sformatf("stall%0d_pt", c), 80'(plaintext), 80'(vecs[2].pt));
        end
        in_valid = 1'b0;
        check("stall_in_ready", 80'(in_ready), 80'(0));
        handshake(vecs[2].pt);
        @(posedge clk);
        @(negedge clk);
        check("stall_no_accept", 80'(in_ready), 80'(1));

        // Back-to-back with out_ready tied high and the next block already offered
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ciphertext = vecs[1].ct;
        key        = vecs[1].key;
        @(posedge clk);
        @(negedge clk);
        ciphertext = vecs[3].ct;
        key        = vecs[3].key;
        wait_done(lat);
        check("b2b_a_pt", 80'(plaintext), 80'(vecs[1].pt));
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle_in_ready", 80'(in_ready), 80'(1));
        check("b2b_idle_out_valid", 80'(out_valid), 80'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_b_busy", 80'(in_ready), 80'(0));
        wait_done(lat);
        check("b2b_b_pt", 80'(plaintext), 80'(vecs[3].pt));
        check("b2b_b_key_reg", dut.key_q, vecs[3].key);
        @(posedge clk);
        @(negedge clk);
        check("b2b_b_taken", 80'(out_valid), 80'(0));
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
